// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared types for the rv32 datapath memory stage: access-size
//               encoding, load/store unit FSM states and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Access size as produced by the decoder; 2'b11 is the illegal encoding.
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } MemSize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // An access is misaligned when it does not sit on its natural boundary,
  // or when the size encoding itself is illegal.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if (size == 2'b11)                      r = 1'b1;
    else if (size == MEM_H && off[0])       r = 1'b1;
    else if (size == MEM_W && off != 2'b00) r = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_extend
// Description : Extracts the addressed byte/half from a read word and sign-
//               or zero-extends it; words pass straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_extend
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_offset,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the lane and extend according to size and signedness.
  always_comb begin
    w_byte = i_rdata[8*i_offset +: 8];
    w_half = i_rdata[16*i_offset[1] +: 16];
    o_data = i_rdata;
    case (i_size)
      MEM_B:   o_data = i_unsigned ? {{(XLEN-8){1'b0}}, w_byte}
                                   : {{(XLEN-8){w_byte[7]}}, w_byte};
      MEM_H:   o_data = i_unsigned ? {{(XLEN-16){1'b0}}, w_half}
                                   : {{(XLEN-16){w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : rv32 memory stage. Issues one req/ready data-memory access per
//               instruction, builds byte lanes and replicated store data,
//               extends load data and stalls the pipeline until completion,
//               misalignment abort or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_lsu_valid,
  input  logic            i_MemRW,
  input  logic [1:0]      i_MemSize,
  input  logic            i_MemUnsigned,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_done,
  output logic            o_stall,
  output logic            o_misaligned,
  output logic            o_bus_err
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int            C_CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_CW-1:0] C_LIMIT = C_CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t      r_state;
  logic [C_CW-1:0] r_cnt;
  logic [1:0]      r_size;
  logic [1:0]      r_off;
  logic            r_unsigned;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_load_data;
  logic            r_done;
  logic            r_misaligned;
  logic            r_bus_err;

  logic            w_misaligned;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ext;
  logic            w_timeout;

  // Lane enables and replicated store data for the access being presented.
  always_comb begin
    w_misaligned = mem_misaligned(i_MemSize, i_addr[1:0]);
    w_be         = 4'b1111;
    w_wdata      = i_wdata;
    case (i_MemSize)
      MEM_B: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      MEM_H: begin
        w_be    = 4'b0011 << {i_addr[1], 1'b0};
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
      end
    endcase
  end

  lsu_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .i_rdata   (i_mem_rdata),
    .i_offset  (r_off),
    .i_size    (r_size),
    .i_unsigned(r_unsigned),
    .o_data    (w_ext)
  );

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == C_LIMIT);

  // Access sequencing: accept, wait for ready or timeout, report once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_unsigned   <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_lsu_valid) begin
            r_bus_err <= 1'b0;
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
              r_done       <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_misaligned <= 1'b0;
              r_addr       <= {i_addr[XLEN-1:2], 2'b00};
              r_we         <= i_MemRW;
              r_be         <= w_be;
              r_wdata      <= w_wdata;
              r_size       <= i_MemSize;
              r_off        <= i_addr[1:0];
              r_unsigned   <= i_MemUnsigned;
              r_req        <= 1'b1;
              r_cnt        <= '0;
              r_state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_mem_ready) begin
            if (!r_we) begin
              r_load_data <= w_ext;
            end
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_req    = r_req;
  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_be     = r_be;
  assign o_mem_wdata  = r_wdata;
  assign o_load_data  = r_load_data;
  assign o_done       = r_done;
  assign o_misaligned = r_misaligned;
  assign o_bus_err    = r_bus_err;
  assign o_stall      = i_lsu_valid & ~r_done;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed vector table,
//               hand-written reset/idle sequences and randomized accesses
//               checked against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, MemRW, MemUnsigned, mem_ready;
  logic [1:0]  MemSize;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, done, stall, misaligned, bus_err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] ld_model = 32'h0;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_lsu_valid(lsu_valid), .i_MemRW(MemRW), .i_MemSize(MemSize),
    .i_MemUnsigned(MemUnsigned), .i_addr(addr), .i_wdata(wdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_load_data(load_data), .o_done(done), .o_stall(stall),
    .o_misaligned(misaligned), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [1:0]  sz;
    bit          un;
    logic [31:0] a, wd, rd;
    int          wt;
    logic [3:0]  be;
    logic [31:0] ewd, eld;
    bit          mis;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: operate on bytes and lanes arithmetically.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic model(input logic [1:0] sz, input bit un, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       output logic [3:0] be, output logic [31:0] ewd,
                       output logic [31:0] eld, output bit mis);
    int nb, off;
    longint v;
    nb  = nbytes(sz);
    off = int'(a % 4);
    mis = (sz == 2'b11) || ((a % nb) != 0);
    be  = 4'b0;
    ewd = 32'h0;
    v   = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) be[i] = 1'b1;
      ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    for (int i = 0; i < nb && (off + i) < 4; i++)
      v = v + (longint'(rd[8*(off+i) +: 8]) << (8*i));
    if (!un && nb < 4 && v >= (longint'(1) << (8*nb - 1)))
      v = v - (longint'(1) << (8*nb));
    eld = v[31:0];
  endtask

  // One full instruction through the unit; wt = cycles before mem_ready.
  task automatic do_access(input string nm, input bit st, input logic [1:0] sz, input bit un,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int wt, input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] eld, input bit emis);
    int c;
    bit to;
    lsu_valid = 1'b1; MemRW = st; MemSize = sz; MemUnsigned = un; addr = a; wdata = wd;
    #1;
    chk({nm, " stall_pre"}, {63'b0, stall}, 64'd1);
    @(posedge clk); #1;
    if (emis) begin
      chk({nm, " mis_resp"}, {60'b0, done, misaligned, mem_req, stall}, {60'b0, 4'b1100});
      chk({nm, " mis_berr"}, {63'b0, bus_err}, 64'd0);
      lsu_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, " mis_done_drop"}, {62'b0, done, mem_req}, 64'd0);
      return;
    end
    chk({nm, " flags_clr"}, {62'b0, misaligned, bus_err}, 64'd0);
    c = 0;
    forever begin
      chk({nm, " busy_bus"}, {26'b0, mem_req, mem_we, mem_be, {a[31:2], 2'b00}},
          {26'b0, 1'b1, st, ebe, {a[31:2], 2'b00}} & 64'hFFFF_FFFF_FFFF_FFFF);
      chk({nm, " busy_wdata"}, {32'b0, mem_wdata}, {32'b0, ewd});
      chk({nm, " busy_hs"}, {62'b0, stall, done}, 64'd2);
      if (c == wt) begin
        mem_ready = 1'b1; mem_rdata = rd;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      c++;
      if (done) break;
      if (c > 40) begin
        chk({nm, " done_bound"}, 64'd0, 64'd1);
        break;
      end
    end
    to = (wt >= TMO);
    chk({nm, " latency"}, 64'(c), to ? 64'(TMO) : 64'(wt + 1));
    chk({nm, " done_flags"}, {60'b0, done, bus_err, misaligned, mem_req}, {60'b0, 1'b1, to, 2'b00});
    chk({nm, " stall_done"}, {63'b0, stall}, 64'd0);
    if (!st && !to) ld_model = eld;
    chk({nm, " load_data"}, {32'b0, load_data}, {32'b0, ld_model});
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, {62'b0, done, mem_req}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rbe;
    logic [31:0] rwd, rld, ra, rw, rr;
    logic [1:0]  rsz;
    bit          rmis, rst_b, run;
    int          rwt;

    rst = 1'b1; lsu_valid = 0; MemRW = 0; MemSize = 0; MemUnsigned = 0;
    addr = 0; wdata = 0; mem_ready = 0; mem_rdata = 0;

    //          st  sz     un  addr          wdata         rdata         wt  be       ewd           eld           mis
    tbl[0]  = '{1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0,  4'b1000, 32'hABABABAB, 32'h0,        0};
    tbl[1]  = '{0, 2'b00, 0, 32'h0000_2002, 32'h0,        32'h12F45678, 1,  4'b0100, 32'h0,        32'hFFFFFFF4, 0};
    tbl[2]  = '{0, 2'b00, 1, 32'h0000_2002, 32'h0,        32'h12F45678, 0,  4'b0100, 32'h0,        32'h000000F4, 0};
    tbl[3]  = '{0, 2'b01, 1, 32'h0000_2002, 32'h0,        32'h12F45678, 2,  4'b1100, 32'h0,        32'h000012F4, 0};
    tbl[4]  = '{0, 2'b01, 0, 32'h0000_2001, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1};
    tbl[5]  = '{0, 2'b10, 0, 32'h0000_2002, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1};
    tbl[6]  = '{0, 2'b10, 0, 32'h0000_3000, 32'h0,        32'h0,        99, 4'b1111, 32'h0,        32'h0,        0};
    tbl[7]  = '{1, 2'b10, 0, 32'h0000_4004, 32'hDEADBEEF, 32'h0,        3,  4'b1111, 32'hDEADBEEF, 32'h0,        0};
    tbl[8]  = '{0, 2'b01, 0, 32'h0000_2000, 32'h0,        32'h12F48678, 0,  4'b0011, 32'h0,        32'hFFFF8678, 0};
    tbl[9]  = '{0, 2'b10, 1, 32'h0000_6000, 32'h0,        32'hCAFEF00D, 15, 4'b1111, 32'h0,        32'hCAFEF00D, 0};
    tbl[10] = '{1, 2'b11, 0, 32'h0000_7000, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {26'b0, mem_req, mem_we, mem_be, done, misaligned, bus_err, stall},
        64'd0);
    chk("reset_addr_wd", {mem_addr, mem_wdata}, 64'd0);
    chk("reset_ld", {32'b0, load_data}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      do_access($sformatf("vec%0d", i), tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].a,
                tbl[i].wd, tbl[i].rd, tbl[i].wt, tbl[i].be, tbl[i].ewd, tbl[i].eld, tbl[i].mis);

    // mem_ready while idle must not start or complete anything.
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ready", {62'b0, done, mem_req}, 64'd0);
    end
    mem_ready = 1'b0;

    // Reset pulse in the middle of BUSY.
    lsu_valid = 1'b1; MemRW = 0; MemSize = 2'b10; MemUnsigned = 0; addr = 32'h8000; wdata = 0;
    @(posedge clk); #1;
    chk("rst_pre_req", {63'b0, mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", {62'b0, mem_req, done}, 64'd0);
    chk("rst_ld", {32'b0, load_data}, 64'd0);
    ld_model = 32'h0;
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_done", {62'b0, done, mem_req}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_access("post_rst_lw", 0, 2'b10, 0, 32'h0000_8000, 32'h0, 32'h13572468, 1,
              4'b1111, 32'h0, 32'h13572468, 0);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 150; i++) begin
      rst_b = 1'b0;
      run   = 1'b1;
      rsz = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = ra[1:0] & ((rsz == 2'b10) ? 2'b00 : (rsz == 2'b01) ? 2'b10 : 2'b11);
      rw  = $urandom;
      rr  = $urandom;
      rwt = ($urandom_range(0, 19) == 0) ? 16 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 5));
      model(rsz, rst_b, ra, rw, rr, rbe, rwd, rld, rmis);
      rst_b = 1'($urandom_range(0, 1));
      model(rsz, rst_b, ra, rw, rr, rbe, rwd, rld, rmis);
      if (run)
        do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rsz, rst_b, ra, rw, rr,
                  rwt, rbe, rwd, rld, rmis);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
